// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: controller FSM states and FIFO entry layout.
package uart_pkg;

    localparam int UART_PAYLOAD_BITS = 8;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic                         last;
        logic [UART_PAYLOAD_BITS-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO with wrap-bit pointers; the head word is visible whenever the FIFO is non-empty.
module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             pop_en;
    logic             push_en;

    assign pop_en  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_en = push && (!full || pop_en);

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign level     = wr_ptr_reg - rd_ptr_reg;
    assign empty     = (level == '0);
    assign full      = (level == (AW+1)'(DEPTH));
    // Gate the head so stale storage never shows on the outputs while empty.
    assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: gates the receiver, stages bytes until their frame position is known,
// and delimits frames by break, idle timeout or shutdown drain.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int PAYLOAD_BITS  = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int IDLE_CYCLES   = 40,
    parameter int COUNT_REG_LEN = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ctrl_enable,
    input  logic                          rx_valid,
    input  logic                          rx_break,
    input  logic [PAYLOAD_BITS-1:0]       rx_data,
    output logic                          rx_en,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [PAYLOAD_BITS-1:0]       m_data,
    output logic                          m_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_errors,
    output logic                          break_det
);
    rx_state_t                state_reg, state_next;
    logic                     stage_valid_reg, stage_valid_next;
    logic [PAYLOAD_BITS-1:0]  stage_data_reg, stage_data_next;
    logic [COUNT_REG_LEN-1:0] idle_cnt_reg, idle_cnt_next;
    logic                     rx_en_reg;
    logic                     overflow_reg, overflow_next;
    logic                     break_det_reg, break_det_next;

    logic                     byte_evt;
    logic                     break_evt;
    logic                     timeout;
    logic                     push_req;
    logic                     push_last;
    logic                     push_ok;
    logic                     set_ovf;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [PAYLOAD_BITS:0]    fifo_head;

    assign byte_evt  = (state_reg == ACTIVE) && rx_valid && !rx_break;
    assign break_evt = (state_reg == ACTIVE) && rx_valid && rx_break;
    assign timeout   = (state_reg == ACTIVE) && stage_valid_reg &&
                       (idle_cnt_reg == COUNT_REG_LEN'(IDLE_CYCLES - 1));
    assign fifo_pop  = m_ready && !fifo_empty;
    assign push_ok   = !fifo_full || fifo_pop;

    always_comb begin
        state_next       = state_reg;
        stage_valid_next = stage_valid_reg;
        stage_data_next  = stage_data_reg;
        idle_cnt_next    = '0;
        push_req         = 1'b0;
        push_last        = 1'b0;
        set_ovf          = 1'b0;
        break_det_next   = 1'b0;

        case (state_reg)
            OFF: begin
                if (ctrl_enable) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!ctrl_enable) begin
                    state_next = DRAIN;
                end
                break_det_next = break_evt;
                // Any event retires the staged byte; only a following data byte keeps the frame open.
                if (stage_valid_reg && (rx_valid || timeout)) begin
                    push_req  = 1'b1;
                    push_last = !byte_evt;
                    set_ovf   = !push_ok;
                end
                if (byte_evt) begin
                    stage_valid_next = 1'b1;
                    stage_data_next  = rx_data;
                end else if (push_req) begin
                    stage_valid_next = 1'b0;
                end else if (stage_valid_reg) begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
                end
            end
            DRAIN: begin
                push_last = 1'b1;
                if (!stage_valid_reg) begin
                    state_next = OFF;
                end else if (push_ok) begin
                    push_req         = 1'b1;
                    stage_valid_next = 1'b0;
                    state_next       = OFF;
                end
            end
            default: begin
                state_next = OFF;
            end
        endcase

        if (set_ovf) begin
            overflow_next = 1'b1;
        end else if (clear_errors) begin
            overflow_next = 1'b0;
        end else begin
            overflow_next = overflow_reg;
        end
    end

    assign fifo_push = push_req && push_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= OFF;
            stage_valid_reg <= 1'b0;
            stage_data_reg  <= '0;
            idle_cnt_reg    <= '0;
            rx_en_reg       <= 1'b0;
            overflow_reg    <= 1'b0;
            break_det_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            stage_valid_reg <= stage_valid_next;
            stage_data_reg  <= stage_data_next;
            idle_cnt_reg    <= idle_cnt_next;
            rx_en_reg       <= (state_next == ACTIVE);
            overflow_reg    <= overflow_next;
            break_det_reg   <= break_det_next;
        end
    end

    uart_rx_fifo #(
        .WIDTH (PAYLOAD_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data ({push_last, stage_data_reg}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign rx_en     = rx_en_reg;
    assign m_valid   = !fifo_empty;
    assign m_data    = fifo_head[PAYLOAD_BITS-1:0];
    assign m_last    = fifo_head[PAYLOAD_BITS];
    assign overflow  = overflow_reg;
    assign break_det = break_det_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus random traffic against a frame-level reference model.
module tb_uart_rx_ctrl;
    localparam int PB    = 8;
    localparam int DEPTH = 8;
    localparam int IDLE  = 40;
    localparam int CRL   = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          ctrl_enable = 1'b0;
    logic          rx_valid = 1'b0;
    logic          rx_break = 1'b0;
    logic [PB-1:0] rx_data = '0;
    logic          m_ready = 1'b0;
    logic          clear_errors = 1'b0;
    logic          rx_en;
    logic          m_valid;
    logic [PB-1:0] m_data;
    logic          m_last;
    logic [3:0]    fifo_level;
    logic          overflow;
    logic          break_det;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .PAYLOAD_BITS  (PB),
        .FIFO_DEPTH    (DEPTH),
        .IDLE_CYCLES   (IDLE),
        .COUNT_REG_LEN (CRL)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ctrl_enable  (ctrl_enable),
        .rx_valid     (rx_valid),
        .rx_break     (rx_break),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .clear_errors (clear_errors),
        .break_det    (break_det)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frame rules applied to a queue, with staging age measured by timestamps.
    logic [PB:0]   mq[$];
    int            mode;       // 0 off, 1 receiving, 2 draining
    int            cyc;
    int            stg_cyc;
    logic          stg_v;
    logic [PB-1:0] stg_d;
    logic          m_ovf;
    logic          m_brk;
    logic          m_rxen;

    always @(posedge clk or negedge resetn) begin
        bit pop, room, do_push, plast, set_ovf, tmo;
        if (!resetn) begin
            mq.delete();
            mode = 0; cyc = 0; stg_cyc = 0; stg_v = 1'b0; stg_d = '0;
            m_ovf = 1'b0; m_brk = 1'b0; m_rxen = 1'b0;
        end else begin
            cyc++;
            pop = (mq.size() != 0) && m_ready;
            room = (mq.size() < DEPTH) || pop;
            do_push = 1'b0; plast = 1'b0; set_ovf = 1'b0;
            m_brk = (mode == 1) && rx_valid && rx_break;
            if (pop) begin
                $display("pop data=0x%02h last=%0d t=%0t", mq[0][PB-1:0], mq[0][PB], $time);
                void'(mq.pop_front());
            end
            case (mode)
                0: if (ctrl_enable) mode = 1;
                1: begin
                    tmo = stg_v && ((cyc - stg_cyc) == IDLE);
                    if (stg_v && (rx_valid || tmo)) begin
                        do_push = 1'b1;
                        plast = !(rx_valid && !rx_break);
                        if (!room) set_ovf = 1'b1;
                    end
                    if (do_push && room) mq.push_back({plast, stg_d});
                    if (rx_valid && !rx_break) begin
                        stg_v = 1'b1; stg_d = rx_data; stg_cyc = cyc;
                    end else if (do_push) begin
                        stg_v = 1'b0;
                    end
                    if (!ctrl_enable) mode = 2;
                end
                default: begin
                    if (!stg_v) mode = 0;
                    else if (room) begin
                        mq.push_back({1'b1, stg_d});
                        stg_v = 1'b0;
                        mode = 0;
                    end
                end
            endcase
            if (set_ovf) m_ovf = 1'b1;
            else if (clear_errors) m_ovf = 1'b0;
            m_rxen = (mode == 1);
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            check("rx_en", 32'(rx_en), 32'(m_rxen));
            check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
            check("fifo_level", 32'(fifo_level), mq.size());
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("break_det", 32'(break_det), 32'(m_brk));
            if (mq.size() != 0) begin
                check("m_data", 32'(m_data), 32'(mq[0][PB-1:0]));
                check("m_last", 32'(m_last), 32'(mq[0][PB]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [PB-1:0] d, input logic b);
        rx_valid = 1'b1; rx_data = d; rx_break = b;
        tick(1);
        rx_valid = 1'b0; rx_break = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_en"}, 32'(rx_en), 0);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_m_data"}, 32'(m_data), 0);
        check({tag, "_m_last"}, 32'(m_last), 0);
        check({tag, "_level"}, 32'(fifo_level), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
        check({tag, "_break_det"}, 32'(break_det), 0);
    endtask

    initial begin
        logic [PB-1:0] abc [3];
        abc[0] = 8'h41; abc[1] = 8'h42; abc[2] = 8'h43;

        tick(3);
        check_all_zero("reset");
        resetn = 1'b1;
        tick(2);
        ctrl_enable = 1'b1; m_ready = 1'b1;
        tick(2);
        check("rx_en_on", 32'(rx_en), 1);

        // Widely spaced bytes each close on timeout; tightly spaced ones form one frame.
        for (int i = 0; i < 3; i++) begin send(abc[i], 1'b0); tick(99); end
        for (int i = 0; i < 3; i++) begin send(abc[i], 1'b0); tick(9); end
        tick(60);

        // Break closes the frame and pulses break_det once.
        send(8'h10, 1'b0); tick(9);
        send(8'h11, 1'b0); tick(9);
        send(8'h00, 1'b1);
        check("break_pulse", 32'(break_det), 1);
        tick(1);
        check("break_once", 32'(break_det), 0);
        tick(60);

        // Overflow with a stalled consumer.
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin send(8'(8'h80 + i), 1'b0); tick(9); end
        tick(60);
        check("ovf_level", 32'(fifo_level), 8);
        check("ovf_set", 32'(overflow), 1);
        clear_errors = 1'b1; tick(1); clear_errors = 1'b0;
        check("ovf_clear", 32'(overflow), 0);
        m_ready = 1'b1;
        tick(20);

        // Drain on disable; bytes while off are ignored.
        send(8'h55, 1'b0); tick(3);
        ctrl_enable = 1'b0;
        tick(1);
        check("rx_en_off", 32'(rx_en), 0);
        tick(5);
        send(8'h66, 1'b0); tick(5);
        check("off_ignored", 32'(fifo_level), 0);

        // Reset mid-operation with entries held.
        ctrl_enable = 1'b1; m_ready = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) begin send(8'(8'hA0 + i), 1'b0); tick(4); end
        check("pre_reset_level", 32'(fifo_level), 3);
        #3 resetn = 1'b0;
        #1 check_all_zero("async_reset");
        tick(2);
        resetn = 1'b1;
        tick(3);
        m_ready = 1'b1;
        tick(60);
        check("no_stale", 32'(m_valid), 0);

        // Push into a full FIFO while it pops.
        m_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin send(8'(8'hC0 + i), 1'b0); tick(2); end
        check("full_level", 32'(fifo_level), 8);
        m_ready = 1'b1;
        send(8'hCF, 1'b0);
        check("full_pp_level", 32'(fifo_level), 8);
        check("full_pp_ovf", 32'(overflow), 0);
        tick(60);

        // Random traffic in phases of varying consumer pressure.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 800; c++) begin
                rx_valid = ($urandom_range(0, 7) == 0);
                rx_break = rx_valid && ($urandom_range(0, 5) == 0);
                rx_data = 8'($urandom);
                m_ready = (ph == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
                clear_errors = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 199) == 0) ctrl_enable = ~ctrl_enable;
                tick(1);
            end
        end
        rx_valid = 1'b0; rx_break = 1'b0; clear_errors = 1'b0; m_ready = 1'b1;
        tick(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
